// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM states,
// PC reset/step constants and the bubble instruction word.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  // Consumers insert this word when they need a bubble.
  localparam logic [31:0] INSN_NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_skid.sv
// One-entry {pc, instr} holding buffer for an instruction that came back
// while IF/ID was stalled. Clear wins over load.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: program counter, imem req/ack fetch, and the IF/ID output
// register backed by a one-entry skid buffer for decode stalls.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  output logic [1:0]  dbg_state
);

  // Handshakes: imem_req/imem_addr stay constant until imem_ack (or a
  // redirect aborts the fetch); a word transfers to IF/ID on any rising
  // edge where if_valid && id_ready, and the output slot may be refilled
  // in that same edge.

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         ov_n;
  logic [31:0]  opc_n, oin_n;
  logic         slot_free;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_pc, skid_instr;

  assign slot_free = !if_valid || id_ready;
  assign pc_plus4  = pc + PC_STEP;
  assign imem_addr = pc;
  assign imem_req  = (state == ST_REQ);
  assign dbg_state = state;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_pc    (pc),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ov_n       = if_valid && !id_ready;
    opc_n      = if_pc;
    oin_n      = if_instr;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    case (state)
      ST_IDLE: state_n = ST_REQ;
      ST_REQ: begin
        if (redirect) begin
          pc_n       = next_pc;
          ov_n       = 1'b0;
          skid_clear = 1'b1;
        end else if (imem_ack) begin
          pc_n = next_pc;
          if (slot_free) begin
            ov_n  = 1'b1;
            opc_n = pc;
            oin_n = imem_rdata;
          end else begin
            skid_load = 1'b1;
            state_n   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Redirect flushes both the presented word and the skid entry.
        if (redirect) begin
          pc_n       = next_pc;
          ov_n       = 1'b0;
          skid_clear = 1'b1;
          state_n    = ST_REQ;
        end else if (slot_free) begin
          ov_n       = skid_valid;
          opc_n      = skid_pc;
          oin_n      = skid_instr;
          skid_clear = 1'b1;
          state_n    = ST_REQ;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= 32'h0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      if_valid <= ov_n;
      if_pc    <= opc_n;
      if_instr <= oin_n;
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end of the pipelined 32-bit core. Holds the program counter, exports pc_plus4 to the in0 input of the PC-select 2:1 mux, and takes that mux's output back as next_pc (mux in1 = branch/jump target, select = redirect).
- Runs a req/ack fetch handshake to instruction memory and hands {pc, instr} to the IF/ID stage with valid/ready.
- Contains a one-entry skid buffer so an instruction returned during a decode stall is not lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- PC_STEP, 4, sequential increment added to pc to form pc_plus4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- next_pc  in  32  output of the PC-select mux; loaded into pc on every advance or redirect.
- redirect  in  1  taken branch/jump from EX; also drives the mux select.
- pc_plus4  out  32  pc + PC_STEP, combinational, to mux in0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- if_valid  out  1  if_pc/if_instr hold a valid instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction.
- id_ready  in  1  IF/ID accepts this cycle; stall = !id_ready.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_PC; state=IDLE; imem_req=0; if_valid=0; if_pc=0; if_instr=0; skid empty.
  - pc_plus4 = RESET_PC+PC_STEP.
  - Reset asserted mid-fetch abandons the fetch; an ack arriving while rst_n=0 is ignored.
- Handshakes:
  - Output slot is free when if_valid=0, or when if_valid=1 and id_ready=1 (transfer).
  - Fetch: a request is held with constant imem_addr until imem_ack, unless aborted by redirect.
- States:
  - IDLE: imem_req=0. Next cycle goes to REQ. Exists only for the first cycle after reset.
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_ack with redirect=0 and slot free: next cycle if_valid=1, if_pc=pc, if_instr=imem_rdata, pc<=next_pc; stay REQ. This gives back-to-back fetch, 1 instr/cycle with single-cycle memory.
    - On imem_ack with redirect=0 and slot not free: write {pc, rdata} to skid, pc<=next_pc, go to HOLD.
  - HOLD: imem_req=0.
    - When slot becomes free: skid moves to output, go to REQ.
    - While id_ready stays 0, output and skid are held.
- Latency: ack at cycle N -> if_valid at N+1. The next request is issued at N+1 with the updated pc.
- Redirect (any state except IDLE, sampled at the edge):
  - pc<=next_pc; if_valid<=0; skid cleared; state<=REQ.
  - An ack in the same cycle is discarded.
  - A request in flight is aborted: imem_addr shows the new pc from the next cycle.
  - Redirect takes priority over ack, stall and HOLD.
- Simultaneous transfer (if_valid & id_ready) and new ack: the output register is overwritten in the same edge; no bubble.
- pc_plus4 arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- next_pc is loaded unchecked; its alignment is the mux producer's responsibility.
- Outputs if_pc/if_instr keep their last value when if_valid=0 (don't-care for consumers).

Decomposition:
- Shared core package:
  - fetch state enum {IDLE, REQ, HOLD}.
  - RESET_PC default and PC_STEP constant.
  - INSN_NOP = 32'h0000_0000 for consumer bubble insertion.
- Sub-module fetch_skid_buf: one-entry {pc, instr} buffer with load/clear/valid.
  - Instantiated once; sync active-low reset.
- The PC-select mux remains external.

Test Plan:
- Reset with RESET_PC=32'h0000_0100; release; memory acks every cycle, id_ready=1.
  - Expect imem_addr 0x100, 0x104, 0x108.
  - Expect if_valid high from the cycle after the first ack.
  - Expect if_pc to follow imem_addr by one cycle.
- Stall: id_ready=0 while if_valid=1 and an ack for 0x108 arrives.
  - Expect HOLD, imem_req=0, if_pc stays 0x104.
  - After id_ready=1: if_pc=0x108 next cycle, then fetch of 0x10C, with no instruction lost or duplicated.
- Redirect with next_pc=0x200 in the same cycle as an ack for 0x10C.
  - Expect the 0x10C instruction dropped and if_valid=0 next cycle.
  - Expect imem_addr=0x200 next cycle; first if_pc after that is 0x200.
- Redirect to 0x300 while in HOLD with the skid full.
  - Expect skid and output cleared and the next request at 0x300.
- Reset asserted while a request is pending with no ack.
  - Expect imem_req=0, if_valid=0, pc=RESET_PC the next cycle.
  - Expect fetch to restart at RESET_PC after IDLE.
- pc=32'hFFFF_FFFC.
  - Expect pc_plus4=0; with sequential advance, the next imem_addr is 0x0000_0000.
